// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core types and constants
package cpu_pkg;
  localparam int INST_ADDR_W = 12;
  typedef logic [31:0] inst_t;
  localparam inst_t NOP_INST = 32'h0000_0013;
  typedef enum logic [0:0] {RUN, FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue of {inst, pc} with synchronous flush
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  inst_t             push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output inst_t             head_inst,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CW-1:0]     count
);
  inst_t             inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr] <= push_pc;
    end
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  // Upstream credit accounting must keep a slot free for every in-flight read
  always_ff @(posedge clk)
    if (!rst && !flush) assert (!(push && count == CW'(DEPTH)));
  assign head_inst = inst_mem[rd_ptr];
  assign head_pc = pc_mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-based prefetch and redirect handling
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, inflight_pc, head_pc;
  logic              inflight, push, pop, credit;
  logic [CW-1:0]     count;
  inst_t             head_inst;
  assign inst_valid = !rst && count != '0;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  // A return landing in FLUSH belongs to the pre-redirect stream
  assign push = inflight && state == RUN;
  assign credit = int'(count) + int'(inflight) + 1 <= DEPTH + int'(pop);
  assign imem_en = !rst && !redirect_valid && credit;
  assign imem_addr = rst ? RESET_PC : pc;
  assign inst = inst_valid ? head_inst : NOP_INST;
  assign inst_pc = head_pc;
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= RESET_PC;
      state <= RUN;
    end else begin
      pc <= redirect_valid ? redirect_pc : imem_en ? pc + 1'b1 : pc;
      inflight <= imem_en;
      inflight_pc <= pc;
      state <= redirect_valid ? FLUSH : RUN;
    end
  fetch_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .push_inst(imem_rdata),
    .push_pc(inflight_pc),
    .pop(pop),
    .head_inst(head_inst),
    .head_pc(head_pc),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against an in-order stream model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [11:0] inst_pc;
  logic [31:0] ram [4096];
  logic [11:0] exp_pc = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          issues;
  int          waited;

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= ram[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instructions must leave in address order from the latest reset/redirect target
  task automatic cyc();
    @(negedge clk);
    if (rst || redirect_valid) chk("en_blocked", 32'(imem_en), 32'd0);
    if (!rst && !redirect_valid && inst_ready && inst_valid) begin
      chk("stream_pc", 32'(inst_pc), 32'(exp_pc));
      chk("stream_inst", inst, ram[exp_pc]);
      exp_pc = exp_pc + 12'd1;
    end
    if (redirect_valid) exp_pc = redirect_pc;
    if (rst) exp_pc = 12'd0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'(i);
    // reset and first-fetch latency
    repeat (3) cyc();
    #1;
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("c0_en", 32'(imem_en), 32'd1);
    chk("c0_addr", 32'(imem_addr), 32'd0);
    chk("c0_valid", 32'(inst_valid), 32'd0);
    cyc();
    chk("c1_valid", 32'(inst_valid), 32'd0);
    chk("c1_addr", 32'(imem_addr), 32'd1);
    cyc();
    chk("c2_valid", 32'(inst_valid), 32'd1);
    chk("c2_pc", 32'(inst_pc), 32'd0);
    chk("c2_inst", inst, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t1_rate", 32'(inst_valid), 32'd1);
    end
    // backpressure: exactly DEPTH fetches while stalled
    rst = 1'b1;
    inst_ready = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      issues += int'(imem_en);
      cyc();
    end
    chk("t2_issues", 32'(issues), 32'd4);
    chk("t2_en_full", 32'(imem_en), 32'd0);
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_head", 32'(inst_pc), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2_nogap", 32'(inst_valid), 32'd1);
    end
    // redirect with full FIFO and one fetch in flight
    inst_ready = 1'b0;
    repeat (6) cyc();
    inst_ready = 1'b1;
    #1;
    chk("t3_issue_on_pop", 32'(imem_en), 32'd1);
    cyc();
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 12'd100;
    cyc();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    chk("t3_en", 32'(imem_en), 32'd1);
    chk("t3_addr", 32'(imem_addr), 32'd100);
    cyc();
    chk("t3_gap", 32'(inst_valid), 32'd0);
    cyc();
    chk("t3_valid", 32'(inst_valid), 32'd1);
    chk("t3_pc", 32'(inst_pc), 32'd100);
    repeat (6) cyc();
    // back-to-back redirects
    redirect_valid = 1'b1;
    redirect_pc = 12'd50;
    cyc();
    redirect_pc = 12'd70;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("t4_valid0", 32'(inst_valid), 32'd0);
    chk("t4_addr", 32'(imem_addr), 32'd70);
    cyc();
    cyc();
    chk("t4_valid", 32'(inst_valid), 32'd1);
    chk("t4_pc", 32'(inst_pc), 32'd70);
    repeat (6) cyc();
    // address wrap
    redirect_valid = 1'b1;
    redirect_pc = 12'd4095;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    chk("t5_pc_top", 32'(inst_pc), 32'd4095);
    cyc();
    chk("t5_valid", 32'(inst_valid), 32'd1);
    chk("t5_pc_wrap", 32'(inst_pc), 32'd0);
    repeat (4) cyc();
    // reset mid-stream with FIFO full
    inst_ready = 1'b0;
    repeat (8) cyc();
    chk("t6_full_en", 32'(imem_en), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_valid0", 32'(inst_valid), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    inst_ready = 1'b1;
    cyc();
    cyc();
    chk("t6_valid", 32'(inst_valid), 32'd1);
    chk("t6_pc", 32'(inst_pc), 32'd0);
    repeat (4) cyc();
    // random traffic on random RAM contents
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      inst_ready = $urandom_range(9) < 7;
      redirect_valid = $urandom_range(19) == 0;
      redirect_pc = 12'($urandom);
      rst = $urandom_range(99) == 0;
      cyc();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    waited = 0;
    #1;
    while (!inst_valid && waited < 8) begin
      cyc();
      waited++;
    end
    chk("drain_valid", 32'(inst_valid), 32'd1);
    repeat (8) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
